// File: rtl/vga_timing_if.sv
// Raster position and sync outputs of the VGA timing generator.
// The master drives every signal; consumers attach through the slave modport.
interface vga_timing_if #(
    parameter int CW = 10
);
    logic [CW-1:0] sx;
    logic [CW-1:0] sy;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          line_start;
    logic          frame_start;

    modport master (output sx, sy, hsync, vsync, de, line_start, frame_start);
    modport slave  (input  sx, sy, hsync, vsync, de, line_start, frame_start);
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with registered sync, data enable
// and line/frame start pulses, all aligned to the same (sx,sy).
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 10
) (
    input  logic         clk_pix,
    input  logic         rst,
    input  logic         clk_locked,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] sx_q;
    logic [CW-1:0] sy_q;
    logic [CW-1:0] nx;
    logic [CW-1:0] ny;
    logic          hsync_q;
    logic          vsync_q;
    logic          de_q;
    logic          line_start_q;
    logic          frame_start_q;

    // The position about to be presented; coming out of idle always restarts at (0,0).
    always_comb begin
        nx = '0;
        ny = '0;
        if (state == ST_RUN) begin
            if (sx_q == H_LAST) begin
                nx = '0;
                ny = (sy_q == V_LAST) ? '0 : sy_q + CW'(1);
            end else begin
                nx = sx_q + CW'(1);
                ny = sy_q;
            end
        end
    end

    // Every output is decoded from the same next position, so they never skew.
    always_ff @(posedge clk_pix) begin
        if (rst || !clk_locked) begin
            state         <= ST_IDLE;
            sx_q          <= '0;
            sy_q          <= '0;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
        end else begin
            state         <= ST_RUN;
            sx_q          <= nx;
            sy_q          <= ny;
            de_q          <= (nx < H_VIS) && (ny < V_VIS);
            line_start_q  <= (nx == '0);
            frame_start_q <= (nx == '0) && (ny == '0);
            hsync_q       <= ((nx >= HS_START) && (nx < HS_END)) ? H_POL : ~H_POL;
            vsync_q       <= ((ny >= VS_START) && (ny < VS_END)) ? V_POL : ~V_POL;
        end
    end

    assign vga.sx          = sx_q;
    assign vga.sy          = sy_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.de          = de_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default 640x480 instance for line-level timing, and a tiny
// raster instance for whole-frame, lock-drop and wrap-around behaviour.
module tb_vga_timing;
    logic clk_pix = 1'b0;
    logic rst_d   = 1'b1;
    logic lock_d  = 1'b1;
    logic rst_s   = 1'b1;
    logic lock_s  = 1'b1;

    vga_timing_if #(.CW(10)) vga_d ();
    vga_timing_if #(.CW(4))  vga_s ();

    vga_timing #(.CW(10)) dut_d (
        .clk_pix   (clk_pix),
        .rst       (rst_d),
        .clk_locked(lock_d),
        .vga       (vga_d)
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0), .CW(4)
    ) dut_s (
        .clk_pix   (clk_pix),
        .rst       (rst_s),
        .clk_locked(lock_s),
        .vga       (vga_s)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct packed {
        logic [9:0] sx;
        logic [9:0] sy;
        logic       de;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } sample_t;

    sample_t sb_q[$];
    int checks = 0;
    int errors = 0;

    bit sel;
    int ht, vt, ha, va, hss, hse, vss, vse;
    bit hpol, vpol;
    int mx, my;
    bit mrun;

    int cyc, last_ls, line_period, hs_acc, de_acc, line_hs, line_de, hs_start;
    int last_fs, frame_period, vs_acc, fde_acc, frame_vs, frame_de, max_sx, max_sy;
    bit prev_hs;

    task automatic resetStats();
        cyc = 0; last_ls = -1; line_period = -1; hs_acc = 0; de_acc = 0;
        line_hs = -1; line_de = -1; hs_start = -1;
        last_fs = -1; frame_period = -1; vs_acc = 0; fde_acc = 0;
        frame_vs = -1; frame_de = -1; max_sx = 0; max_sy = 0;
        prev_hs = ~hpol;
    endtask

    // Expected raster constants come straight from the timing numbers, not from the DUT.
    task automatic configure(input bit s);
        sel = s;
        if (!s) begin
            ha = 640; ht = 800; hss = 656; hse = 752;
            va = 480; vt = 525; vss = 490; vse = 492;
            hpol = 1'b0; vpol = 1'b0;
        end else begin
            ha = 8; ht = 14; hss = 10; hse = 13;
            va = 4; vt = 7;  vss = 5;  vse = 6;
            hpol = 1'b1; vpol = 1'b0;
        end
        mrun = 1'b0; mx = 0; my = 0;
        sb_q.delete();
        resetStats();
    endtask

    task automatic applyStimulus(input bit r, input bit lk);
        sample_t e;
        if (sel) begin rst_s = r; lock_s = lk; end
        else     begin rst_d = r; lock_d = lk; end
        if (r || !lk) begin
            mrun = 1'b0;
            e.sx = '0; e.sy = '0; e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
            e.hs = ~hpol; e.vs = ~vpol;
        end else begin
            if (!mrun) begin
                mrun = 1'b1; mx = 0; my = 0;
            end else begin
                mx++;
                if (mx == ht) begin
                    mx = 0;
                    my++;
                    if (my == vt) my = 0;
                end
            end
            e.sx = 10'(mx);
            e.sy = 10'(my);
            e.de = (mx < ha) && (my < va);
            e.hs = (mx >= hss && mx < hse) ? hpol : ~hpol;
            e.vs = (my >= vss && my < vse) ? vpol : ~vpol;
            e.ls = (mx == 0);
            e.fs = (mx == 0) && (my == 0);
        end
        sb_q.push_back(e);
    endtask

    function automatic sample_t observe();
        sample_t o;
        if (sel) begin
            o.sx = {6'b0, vga_s.sx}; o.sy = {6'b0, vga_s.sy};
            o.de = vga_s.de; o.hs = vga_s.hsync; o.vs = vga_s.vsync;
            o.ls = vga_s.line_start; o.fs = vga_s.frame_start;
        end else begin
            o.sx = vga_d.sx; o.sy = vga_d.sy;
            o.de = vga_d.de; o.hs = vga_d.hsync; o.vs = vga_d.vsync;
            o.ls = vga_d.line_start; o.fs = vga_d.frame_start;
        end
        return o;
    endfunction

    task automatic updateStats(input sample_t o);
        cyc++;
        if (o.ls === 1'b1) begin
            if (last_ls >= 0) begin
                line_period = cyc - last_ls; line_hs = hs_acc; line_de = de_acc;
            end
            last_ls = cyc; hs_acc = 0; de_acc = 0;
        end
        if (o.fs === 1'b1) begin
            if (last_fs >= 0) begin
                frame_period = cyc - last_fs; frame_vs = vs_acc; frame_de = fde_acc;
            end
            last_fs = cyc; vs_acc = 0; fde_acc = 0;
        end
        if (o.hs === hpol) begin
            hs_acc++;
            if (prev_hs !== hpol) hs_start = int'(o.sx);
        end
        prev_hs = o.hs;
        if (o.de === 1'b1) begin de_acc++; fde_acc++; end
        if (o.vs === vpol) vs_acc++;
        if (int'(o.sx) > max_sx) max_sx = int'(o.sx);
        if (int'(o.sy) > max_sy) max_sy = int'(o.sy);
    endtask

    task automatic checkOutput(input string tag);
        sample_t e, o;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("[TB] FAIL %s scoreboard empty observed=0 expected=1", tag);
        end
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        o = observe();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("[TB] FAIL %s observed sx=%0d sy=%0d de=%b hs=%b vs=%b ls=%b fs=%b expected sx=%0d sy=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                   tag, o.sx, o.sy, o.de, o.hs, o.vs, o.ls, o.fs,
                   e.sx, e.sy, e.de, e.hs, e.vs, e.ls, e.fs);
        end
        updateStats(o);
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        checks++;
        assert (observed == expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step(input bit r, input bit lk, input string tag);
        applyStimulus(r, lk);
        @(posedge clk_pix);
        @(negedge clk_pix);
        checkOutput(tag);
    endtask

    // Bounded walk to a raster position; an unreachable target shows up as a failed check.
    task automatic runTo(input int x, input int y, input string tag);
        int n = 0;
        while (!(mrun && mx == x && my == y) && n < 2000) begin
            step(1'b0, 1'b1, tag);
            n++;
        end
        checkValue({tag, "_sx"}, int'(observe().sx), x);
        checkValue({tag, "_sy"}, int'(observe().sy), y);
    endtask

    initial begin
        @(negedge clk_pix);

        configure(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "d_reset");
        for (int i = 0; i < 1700; i++) step(1'b0, 1'b1, "d_run");
        checkValue("d_line_period", line_period, 800);
        checkValue("d_hsync_len", line_hs, 96);
        checkValue("d_hsync_start", hs_start, 656);
        checkValue("d_de_per_line", line_de, 640);
        checkValue("d_max_sx", max_sx, 799);
        runTo(300, 2, "d_walk");
        step(1'b1, 1'b0, "d_rst_over_lock");
        step(1'b1, 1'b1, "d_rst_midline");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "d_restart");

        rst_d = 1'b1;
        configure(1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "s_reset");
        for (int i = 0; i < 225; i++) step(1'b0, 1'b1, "s_run");
        checkValue("s_line_period", line_period, 14);
        checkValue("s_hsync_len", line_hs, 3);
        checkValue("s_hsync_start", hs_start, 10);
        checkValue("s_de_per_line", line_de, 8);
        checkValue("s_frame_period", frame_period, 98);
        checkValue("s_vsync_cycles", frame_vs, 14);
        checkValue("s_de_per_frame", frame_de, 32);
        checkValue("s_max_sx", max_sx, 13);
        checkValue("s_max_sy", max_sy, 6);

        runTo(5, 2, "s_walk_drop");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "s_unlocked");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "s_relock");

        runTo(13, 6, "s_walk_wrap");
        step(1'b1, 1'b1, "s_rst_at_last");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "s_after_rst");
        runTo(13, 6, "s_walk_wrap2");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "s_natural_wrap");
        checkValue("s_bound_sx", max_sx, 13);
        checkValue("s_bound_sy", max_sy, 6);
        checkValue("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 Parameter H_POL, 0, hsync active level (0 = active-low).
REQ-010 Parameter V_POL, 0, vsync active level (0 = active-low).
REQ-011 Parameter CW, 10, coordinate width; SHALL satisfy 2^CW >= both H_TOTAL and V_TOTAL.
REQ-012 clk_pix  in  1  pixel clock; the block SHALL use this one clock only.
REQ-013 rst  in  1  reset; SHALL be synchronous and active-high.
REQ-014 clk_locked  in  1  pixel clock lock, already synchronised to clk_pix; 0 holds the block idle.
REQ-015 sx  out  CW  current horizontal position, 0..H_TOTAL-1.
REQ-016 sy  out  CW  current vertical position, 0..V_TOTAL-1.
REQ-017 hsync  out  1  horizontal sync at polarity H_POL.
REQ-018 vsync  out  1  vertical sync at polarity V_POL.
REQ-019 de  out  1  data enable, high only on visible pixels.
REQ-020 line_start  out  1  one-cycle pulse on sx=0 of every line.
REQ-021 frame_start  out  1  one-cycle pulse on (sx,sy)=(0,0).

Function
REQ-022 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
REQ-023 All outputs SHALL be driven from registers; in any cycle every output describes the same (sx,sy), with no skew between outputs.
REQ-024 Run state: the block runs when rst=0 and clk_locked=1 are sampled together at a rising edge of clk_pix; otherwise it is idle.
REQ-025 First run edge after idle: the outputs SHALL present (0,0) with de=1, line_start=1 and frame_start=1.
REQ-026 Each further run edge: sx increments by 1; at sx=H_TOTAL-1 it wraps to 0 and sy increments.
REQ-027 At sy=V_TOTAL-1 with sx=H_TOTAL-1, the next edge SHALL present (0,0); sx and sy SHALL never exceed H_TOTAL-1 or V_TOTAL-1.
REQ-028 de=1 iff sx<H_ACTIVE and sy<V_ACTIVE.
REQ-029 hsync SHALL be active iff H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC (default sx 656..751), on every line including blanking lines.
REQ-030 vsync SHALL be active iff V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC (default sy 490..491), for whole lines, changing only at sx=0.
REQ-031 line_start=1 iff sx=0; frame_start=1 iff sx=0 and sy=0; each pulse is exactly one cycle.
REQ-032 Arithmetic is unsigned CW-bit; comparisons use parameter-derived constants only, with no multipliers.

Reset
REQ-033 Idle values: sx=0, sy=0, de=0, line_start=0, frame_start=0, hsync=~H_POL, vsync=~V_POL.
REQ-034 rst=1 or clk_locked=0 sampled at any point, including mid-line or mid-frame, SHALL force idle values after that same edge. rst takes priority over clk_locked.
REQ-035 Leaving idle SHALL always restart at (0,0) per REQ-025; no position is retained across idle.

Verification
REQ-036 rst=1 for 5 cycles with clk_locked=1, then rst=0 -> first run edge gives sx=0, sy=0, de=1, frame_start=1, line_start=1; the next edge gives sx=1 with both pulses 0.
REQ-037 Run one full line -> line_start period 800 cycles; hsync low for exactly 96 cycles from sx=656; de high for 640 cycles per visible line.
REQ-038 Run two frames -> frame_start period 420000 cycles; vsync low for 1600 cycles starting at (0,490); 307200 de cycles per frame.
REQ-039 Drop clk_locked at (100,200) for 3 cycles, then restore -> idle values after the drop edge; on re-lock, restart at (0,0) with frame_start=1.
REQ-040 Assert rst for 1 cycle at (799,524) -> idle values after that edge; the following run edge gives (0,0). Check no (800,y) or (x,525) ever appears.
REQ-041 Parameters H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, H_POL=1 -> line period 14 cycles, hsync high for sx 10..12, frame period 98 cycles.
